// File: rtl/uart_rx_fifo_pkg.sv
// Purpose: shared widths and defaults for the UART receive-side byte buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx_fifo_pkg;

  // Width of one UART character.
  localparam int UART_DATA_W = 8;

  // Default buffer geometry.
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AFULL_LVL = 12;

  // Width and ceiling of the dropped-byte counter.
  localparam int         OVR_CNT_W   = 8;
  localparam logic [7:0] OVR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Purpose: DEPTH x DW register array used as FIFO storage.
// Latency: write lands on the next clk edge; read is combinational from the addressed entry.
// Backpressure: none; the caller gates writes.
// Ports: clk; we/waddr/wdata form the synchronous write port; raddr/rdata form the async read port.
// Storage is deliberately not reset.
module fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Purpose: byte FIFO behind the UART receiver; captures rx_done strobes, serves bytes FWFT, flags overrun.
// Latency: a byte captured at edge N is visible on dout (dout_valid=1) in cycle N+1; no extra read latency.
// Backpressure: consumer stalls with dout_ready=0; the receiver cannot be stalled, so bytes arriving
//               while full (and no pop in the same cycle) are dropped and overrun is set.
// Ports: clk, rst (async, active-low); rx_done/rx_data in from receiver; dout_valid/dout_ready/dout
//        to the consumer; level/almost_full/full occupancy status; overrun (sticky) cleared by clr_ovr;
//        ovr_cnt dropped-byte count.
// Build option: define UART_RX_FIFO_OVR_CNT_EN to build a saturating dropped-byte counter on ovr_cnt;
//               otherwise ovr_cnt is tied to zero.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_LVL = DEF_AFULL_LVL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_done,
  input  logic [UART_DATA_W-1:0] rx_data,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [UART_DATA_W-1:0] dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full,
  output logic                   full,
  output logic                   overrun,
  input  logic                   clr_ovr,
  output logic [OVR_CNT_W-1:0]   ovr_cnt
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] AFULL_THR = (AW+1)'(AFULL_LVL);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        push;
  logic        pop;
  logic        drop;

  always_comb begin
    empty       = (wr_ptr == rd_ptr);
    full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    level       = wr_ptr - rd_ptr;
    dout_valid  = !empty;
    almost_full = (level >= AFULL_THR);
    pop         = dout_valid && dout_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
    push        = rx_done && (!full || pop);
    drop        = rx_done && full && !pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // A drop in the same cycle as clr_ovr keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_OVR_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_cnt <= '0;
    end else if (drop) begin
      // Clear-and-drop together leaves exactly this one drop counted.
      if (clr_ovr) begin
        ovr_cnt <= OVR_CNT_W'(1);
      end else if (ovr_cnt != OVR_CNT_MAX) begin
        ovr_cnt <= ovr_cnt + OVR_CNT_W'(1);
      end
    end else if (clr_ovr) begin
      ovr_cnt <= '0;
    end
  end
`else
  assign ovr_cnt = '0;
`endif

  fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (UART_DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (dout)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose: self-checking bench for uart_rx_fifo using a byte-queue reference model and scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_fifo;

  localparam int DEPTH     = 16;
  localparam int AFULL_LVL = 12;

  logic       clk;
  logic       rst;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       dout_valid;
  logic       dout_ready;
  logic [7:0] dout;
  logic [4:0] level;
  logic       almost_full;
  logic       full;
  logic       overrun;
  logic       clr_ovr;
  logic [7:0] ovr_cnt;

  uart_rx_fifo #(
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout        (dout),
    .level       (level),
    .almost_full (almost_full),
    .full        (full),
    .overrun     (overrun),
    .clr_ovr     (clr_ovr),
    .ovr_cnt     (ovr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: occupancy count, sticky flag, drop count, and the expected byte order.
  int         mdl_level;
  bit         mdl_ovr;
  int         mdl_cnt;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  bit         mon_en;

  int n_checks;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies the inputs that were held over the edge just taken to the model.
  task automatic model_update();
    bit p_pop;
    bit p_push;
    bit p_drop;
    if (!rst) return;
    p_pop  = (mdl_level > 0) && dout_ready;
    p_push = rx_done && ((mdl_level < DEPTH) || p_pop);
    p_drop = rx_done && !p_push;
    if (p_push) exp_q.push_back(rx_data);
    mdl_level = mdl_level + int'(p_push) - int'(p_pop);
    if (p_drop) begin
      mdl_ovr = 1'b1;
      if (clr_ovr) mdl_cnt = 1;
      else if (mdl_cnt < 255) mdl_cnt = mdl_cnt + 1;
    end else if (clr_ovr) begin
      mdl_ovr = 1'b0;
      mdl_cnt = 0;
    end
  endtask

  task automatic step(input logic rx, input logic [7:0] d, input logic rdy, input logic clr);
    @(posedge clk);
    model_update();
    #1;
    rx_done    = rx;
    rx_data    = d;
    dout_ready = rdy;
    clr_ovr    = clr;
  endtask

  // Monitor: status against the model every cycle, data against the scoreboard on each handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("level", 32'(level), 32'(mdl_level));
      chk("dout_valid", 32'(dout_valid), 32'(mdl_level > 0));
      chk("full", 32'(full), 32'(mdl_level == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(mdl_level >= AFULL_LVL));
      chk("overrun", 32'(overrun), 32'(mdl_ovr));
`ifdef UART_RX_FIFO_OVR_CNT_EN
      chk("ovr_cnt", 32'(ovr_cnt), 32'(mdl_cnt));
`else
      chk("ovr_cnt", 32'(ovr_cnt), 32'h0);
`endif
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dout_unexpected: got 0x%0h, expected no byte at %0t", dout, $time);
        end else begin
          exp_b = exp_q.pop_front();
          chk("dout_order", 32'(dout), 32'(exp_b));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pushed;
    n_checks   = 0;
    n_fail     = 0;
    mdl_level  = 0;
    mdl_ovr    = 1'b0;
    mdl_cnt    = 0;
    mon_en     = 1'b0;
    rst        = 1'b1;
    rx_done    = 1'b0;
    rx_data    = 8'h00;
    dout_ready = 1'b0;
    clr_ovr    = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_dout_valid", 32'(dout_valid), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_almost_full", 32'(almost_full), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_ovr_cnt", 32'(ovr_cnt), 32'h0);
    rst    = 1'b1;
    mon_en = 1'b1;

    // 1: single byte, then a pop; ready while empty is ignored.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t1_dout", 32'(dout), 32'hA5);
    chk("t1_level", 32'(level), 32'h1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t1_empty", 32'(dout_valid), 32'h0);

    // 2: fill to full with 00..0F.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2_full", 32'(full), 32'h1);

    // 3: drops while full, drop together with clear, counter saturation, clear.
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t3_overrun", 32'(overrun), 32'h1);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t3_set_wins", 32'(overrun), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t3_cleared", 32'(overrun), 32'h0);
    repeat (260) step(1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // 4: push and pop together while full; 8'h77 goes in the freed slot and drains last.
    step(1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t4_level", 32'(level), 32'(DEPTH));
    chk("t4_overrun", 32'(overrun), 32'h0);
    repeat (DEPTH) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t4_drained", 32'(level), 32'h0);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'h0);

    // 5: random stream of 40 bytes with random consumer readiness.
    pushed = 0;
    for (int c = 0; c < 2000 && pushed < 40; c++) begin
      logic rx;
      rx = 1'($urandom_range(0, 1));
      if (rx) pushed++;
      step(rx, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
    chk("t5_all_issued", 32'(pushed), 32'd40);
    repeat (DEPTH + 2) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_drained", 32'(level), 32'h0);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'h0);

    // 6: async reset mid-stream at level 7, then a clean push after release.
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_pre_level", 32'(level), 32'd7);
    @(posedge clk);
    model_update();
    #1;
    rst = 1'b0;
    #1;
    chk("t6_rst_level", 32'(level), 32'h0);
    chk("t6_rst_valid", 32'(dout_valid), 32'h0);
    chk("t6_rst_overrun", 32'(overrun), 32'h0);
    mdl_level = 0;
    mdl_ovr   = 1'b0;
    mdl_cnt   = 0;
    exp_q.delete();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_dout", 32'(dout), 32'h3C);
    chk("t6_level", 32'(level), 32'h1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'h0);

    @(posedge clk);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
